// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared types and constants for the ALU control sequencer:
//               state encoding, opcodes, ALU select codes, IR field positions.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP    = 3'd0,
        CL_3REG   = 3'd1,
        CL_MULDIV = 3'd2,
        CL_UNARY  = 3'd3,
        CL_HALT   = 3'd4
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_NEG  = 5'b10000;
    localparam logic [4:0] OP_NOT  = 5'b10001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SHR = 4'b0010;
    localparam logic [3:0] ALU_SHL = 4'b0011;
    localparam logic [3:0] ALU_ROR = 4'b0100;
    localparam logic [3:0] ALU_ROL = 4'b0101;
    localparam logic [3:0] ALU_AND = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_DIV = 4'b1001;
    localparam logic [3:0] ALU_NEG = 4'b1010;
    localparam logic [3:0] ALU_NOT = 4'b1011;

    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;
    localparam int REG_SEL_W  = 4;

    function automatic op_class_e op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR:  return CL_3REG;
            OP_MUL, OP_DIV:                 return CL_MULDIV;
            OP_NEG, OP_NOT:                 return CL_UNARY;
            OP_HALT:                        return CL_HALT;
            default:                        return CL_NOP;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_select_decoder.sv
`default_nettype none
// ============================================================================
// Module      : reg_select_decoder
// Description : Binary register select plus enable to one-hot enable vector.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_select_decoder #(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
) (
    input  logic [SEL_W-1:0]    sel_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
        assign onehot_o[i] = en_i && (sel_i == SEL_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_sequencer
// Description : Hardwired fetch/execute control unit for ALU-class instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OP_W     = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         IR,
    input  logic                stop,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLowout,
    output logic                ZHighout,
    output logic                HIin,
    output logic                LOin,
    output logic [3:0]          ALUselect,
    output logic                run
);

    state_e                 state_q;
    state_e                 state_d;
    logic [OP_W-1:0]        opcode;
    op_class_e              op_cls;
    logic [REG_SEL_W-1:0]   ra, rb, rc;
    logic [REG_SEL_W-1:0]   rin_sel, rout_sel;
    logic                   rin_en, rout_en;
    logic                   unused_ir;

    assign opcode    = IR[IR_OPC_LSB +: OP_W];
    assign op_cls    = op_class(opcode);
    assign ra        = IR[IR_RA_LSB +: REG_SEL_W];
    assign rb        = IR[IR_RB_LSB +: REG_SEL_W];
    assign rc        = IR[IR_RC_LSB +: REG_SEL_W];
    assign unused_ir = ^IR[IR_RC_LSB-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rin_sel   = '0;
        rout_sel  = '0;
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        Read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        ZLowout   = 1'b0;
        ZHighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ALUselect = ALU_ADD;
        run       = (state_q != ST_RST) && (state_q != ST_HALT);

        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_d = ST_T1;
            end
            ST_T1: begin
                ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                state_d = ST_T2;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                state_d = ST_T3;
            end
            ST_T3: begin
                case (op_cls)
                    CL_3REG:   begin rout_en = 1'b1; rout_sel = rb; Yin = 1'b1; state_d = ST_T4; end
                    CL_MULDIV: begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; state_d = ST_T4; end
                    CL_UNARY: begin
                        rout_en = 1'b1; rout_sel = rb; Zin = 1'b1;
                        ALUselect = alu_code(opcode);
                        state_d = ST_T4;
                    end
                    CL_HALT:   state_d = ST_HALT;
                    default:   state_d = ST_T0;
                endcase
            end
            ST_T4: begin
                case (op_cls)
                    CL_3REG: begin
                        rout_en = 1'b1; rout_sel = rc; Zin = 1'b1;
                        ALUselect = alu_code(opcode);
                        state_d = ST_T5;
                    end
                    CL_MULDIV: begin
                        rout_en = 1'b1; rout_sel = rb; Zin = 1'b1;
                        ALUselect = alu_code(opcode);
                        state_d = ST_T5;
                    end
                    CL_UNARY: begin
                        ZLowout = 1'b1; rin_en = 1'b1; rin_sel = ra;
                        state_d = stop ? ST_HALT : ST_T0;
                    end
                    default: state_d = ST_T0;
                endcase
            end
            ST_T5: begin
                case (op_cls)
                    CL_3REG: begin
                        ZLowout = 1'b1; rin_en = 1'b1; rin_sel = ra;
                        state_d = stop ? ST_HALT : ST_T0;
                    end
                    CL_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; state_d = ST_T6; end
                    default:   state_d = ST_T0;
                endcase
            end
            ST_T6: begin
                ZHighout = 1'b1; HIin = 1'b1;
                state_d = stop ? ST_HALT : ST_T0;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase

        // Reset silences every output in the same cycle, not just after the edge.
        if (reset) begin
            rin_en = 1'b0; rout_en = 1'b0;
            PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
            Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
            Yin = 1'b0; Zin = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0;
            HIin = 1'b0; LOin = 1'b0; ALUselect = ALU_ADD; run = 1'b0;
        end
    end

    reg_select_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_rin_dec (
        .sel_i    (rin_sel),
        .en_i     (rin_en),
        .onehot_o (Rin)
    );

    reg_select_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(REG_SEL_W)) u_rout_dec (
        .sel_i    (rout_sel),
        .en_i     (rout_en),
        .onehot_o (Rout)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_sequencer
// Description : Scoreboard bench for alu_control_sequencer with an
//               instruction-level reference model and randomized programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR;
    logic        stop;
    logic [15:0] Rin, Rout;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, ZLowout, ZHighout, HIin, LOin, run;
    logic [3:0]  ALUselect;

    always #5 clk = ~clk;

    alu_control_sequencer #(.NUM_REGS(16), .OP_W(5)) dut (
        .clk(clk), .reset(reset), .IR(IR), .stop(stop),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout),
        .HIin(HIin), .LOin(LOin), .ALUselect(ALUselect), .run(run)
    );

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, pcin, incpc, marin, read, mdrin, mdrout, irin;
        logic yin, zin, zlowout, zhighout, hiin, loin;
        logic [3:0] alusel;
        logic run;
    } outs_t;

    typedef struct {
        outs_t exp;
        string name;
    } item_t;

    typedef struct {
        logic [31:0] ir;
        int          stop_step;   // -1 never, -2 random each cycle
        int          reset_step;  // -1 never
        int          halt_wait;
    } rec_t;

    outs_t act;
    assign act = {Rin, Rout, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                  Yin, Zin, ZLowout, ZHighout, HIin, LOin, ALUselect, run};

    item_t sb[$];
    rec_t  recs[$];
    int    checks   = 0;
    int    failures = 0;

    function automatic bit is_3reg(input logic [4:0] op);
        return (op >= 5'd3) && (op <= 5'd10);
    endfunction
    function automatic bit is_muldiv(input logic [4:0] op);
        return (op == 5'd14) || (op == 5'd15);
    endfunction
    function automatic bit is_unary(input logic [4:0] op);
        return (op == 5'd16) || (op == 5'd17);
    endfunction

    // Index of the final step (T-number) an instruction occupies.
    function automatic int last_step(input logic [31:0] ir);
        logic [4:0] op = ir[31:27];
        if (is_3reg(op))   return 5;
        if (is_muldiv(op)) return 6;
        if (is_unary(op))  return 4;
        return 3;
    endfunction

    // Expected strobes for step k of the instruction held in ir.
    function automatic outs_t micro(input logic [31:0] ir, input int k);
        outs_t       o;
        logic [4:0]  op  = ir[31:27];
        logic [15:0] one = 16'd1;
        logic [15:0] ra  = one << ir[26:23];
        logic [15:0] rb  = one << ir[22:19];
        logic [15:0] rc  = one << ir[18:15];
        o = '0;
        o.run = 1'b1;
        case (k)
            0: begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1; end
            1: begin o.zlowout = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; end
            2: begin o.mdrout = 1; o.irin = 1; end
            3: begin
                if (is_3reg(op))        begin o.rout = rb; o.yin = 1; end
                else if (is_muldiv(op)) begin o.rout = ra; o.yin = 1; end
                else if (is_unary(op))  begin o.rout = rb; o.zin = 1; o.alusel = 4'(op - 5'd6); end
            end
            4: begin
                if (is_3reg(op))        begin o.rout = rc; o.zin = 1; o.alusel = 4'(op - 5'd3); end
                else if (is_muldiv(op)) begin o.rout = rb; o.zin = 1; o.alusel = 4'(op - 5'd6); end
                else if (is_unary(op))  begin o.zlowout = 1; o.rin = ra; end
            end
            5: begin
                if (is_3reg(op))        begin o.zlowout = 1; o.rin = ra; end
                else if (is_muldiv(op)) begin o.zlowout = 1; o.loin = 1; end
            end
            6: if (is_muldiv(op)) begin o.zhighout = 1; o.hiin = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic add_rec(input logic [31:0] ir, input int s, input int r, input int h);
        rec_t x;
        x.ir = ir; x.stop_step = s; x.reset_step = r; x.halt_wait = h;
        recs.push_back(x);
    endtask

    // Monitor: the DUT presents a full strobe set every cycle.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                it = sb.pop_front();
                checks++;
                if (act !== it.exp) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        int    ph;       // -1 RST, -2 HALT, 0..6 = T-step
        int    hcnt;
        int    cyc;
        bit    rst_now, stop_now;
        rec_t  cur;
        item_t it;
        int    ops[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 14, 15, 16, 17, 27};
        logic [4:0] op;

        reset = 1'b1; stop = 1'b0; IR = '0;
        ph = -1; hcnt = 0; cyc = 0;
        cur.ir = '0; cur.stop_step = -1; cur.reset_step = -1; cur.halt_wait = 0;

        add_rec(32'h4A920000, -1, -1, 0);   // and R5,R2,R4
        add_rec(32'h71200000, -1, -1, 0);   // mul R2,R4
        add_rec(32'h81200000, -1, -1, 0);   // neg R2,R4
        add_rec(32'h1A920000,  5, -1, 20);  // add, stop in T5 -> HALT for 20 cycles
        add_rec(32'h1A920000,  3, -1, 0);   // stop only in T3 -> ignored
        add_rec(32'hD8000000, -1, -1, 3);   // halt opcode
        add_rec(32'hF8000000, -1, -1, 0);   // undefined -> nop
        add_rec(32'h22920000, -1,  4, 0);   // sub, reset during T4
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) op = 5'(ops[$urandom_range(0, 12)]);
            else                          op = 5'($urandom_range(0, 31));
            add_rec({op, 27'($urandom)}, -2,
                    ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 6)) : -1,
                    int'($urandom_range(1, 4)));
        end

        forever begin
            @(posedge clk);
            #1;
            if (ph == 0) begin
                if (recs.size() == 0) break;
                cur = recs.pop_front();
            end
            rst_now  = (cyc < 2) || (ph >= 0 && ph == cur.reset_step) ||
                       (ph == -2 && hcnt >= cur.halt_wait);
            stop_now = (cur.stop_step == -2) ? ($urandom_range(0, 3) == 0)
                                             : (ph >= 0 && ph == cur.stop_step);
            if (ph == 3) IR = cur.ir;
            reset = rst_now;
            stop  = stop_now;

            if (rst_now)       begin it.exp = '0; it.name = "reset"; end
            else if (ph == -1) begin it.exp = '0; it.name = "RST"; end
            else if (ph == -2) begin it.exp = '0; it.name = "HALT"; end
            else begin
                it.exp  = micro(IR, ph);
                it.name = $sformatf("T%0d_ir%h", ph, IR);
            end
            sb.push_back(it);

            if (rst_now)        ph = -1;
            else if (ph == -1)  ph = 0;
            else if (ph == -2)  hcnt++;
            else if (ph == last_step(IR)) begin
                if (IR[31:27] == 5'd27 || (ph > 3 && stop_now)) begin
                    ph = -2; hcnt = 0;
                end else begin
                    ph = 0;
                end
            end else begin
                ph++;
            end
            cyc++;
        end

        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
